// File: rtl/io_pad_pkg.sv
// Shared types and helpers for the pad-cell blocks: FSM state encoding,
// dead-time bound and conflict-free pull resolution.
package io_pad_pkg;

    typedef enum logic [1:0] {
        HIZ      = 2'd0,
        TURN_ON  = 2'd1,
        DRIVE    = 2'd2,
        TURN_OFF = 2'd3
    } io_out_state_t;

    localparam int IO_DEAD_CYC_MAX = 15;

    typedef struct packed {
        logic pu;
        logic pd;
    } pull_pair_t;

    // Both pulls requested at once is a conflict: release both.
    function automatic pull_pair_t pull_resolve(input logic pu_req, input logic pd_req);
        pull_pair_t r;
        r.pu = pu_req & ~pd_req;
        r.pd = pd_req & ~pu_req;
        return r;
    endfunction

endpackage

// File: rtl/io_dead_timer.sv
// Loadable down-counter shared by both turnaround states. Holds at zero.
module io_dead_timer #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic [CNT_W-1:0] value,
    output logic             zero
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    // Load has priority over decrement; never wraps below zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            value <= '0;
        end else if (load) begin
            value <= load_val;
        end else if (dec && (value != '0)) begin
            value <= value - ONE;
        end
    end

    assign zero = (value == '0);

endmodule

// File: rtl/io_out_seq.sv
// Output-direction pad sequencer: registers data/enable requests and drives
// PAD, PAD_OE and PU/PD with break-before-make dead time in both directions.
// Optional feature macro IO_OUT_SEQ_CONTENTION_CHECK_EN adds PAD_IN/CLR_FLAG
// inputs and a sticky CONTENTION flag comparing pad readback with PAD.
// Handshake: none; OE_REQ is a level request sampled every clock, and the
// sequencer acknowledges through DRIVING (driver on) and BUSY (turnaround).
module io_out_seq #(
    parameter int DEAD_CYC = 2,
    parameter int CNT_W    = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       A,
    input  logic       OE_REQ,
    input  logic       PU_REQ,
    input  logic       PD_REQ,
`ifdef IO_OUT_SEQ_CONTENTION_CHECK_EN
    input  logic       PAD_IN,
    input  logic       CLR_FLAG,
    output logic       CONTENTION,
`endif
    output logic       PAD,
    output logic       PAD_OE,
    output logic       PU,
    output logic       PD,
    output logic       DRIVING,
    output logic       BUSY,
    output logic [1:0] state_dbg
);

    import io_pad_pkg::*;

    if ((DEAD_CYC < 1) || (DEAD_CYC > IO_DEAD_CYC_MAX)) begin : g_bad_dead_cyc
        $error("io_out_seq: DEAD_CYC must be in 1..15");
    end
    if (DEAD_CYC > ((1 << CNT_W) - 1)) begin : g_bad_cnt_w
        $error("io_out_seq: CNT_W too narrow for DEAD_CYC");
    end

    // Counter is reloaded with DEAD_CYC-1 so each turnaround spans DEAD_CYC cycles.
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(DEAD_CYC - 1);

    io_out_state_t    state, state_nx;
    logic             tmr_load, tmr_dec, tmr_zero;
    logic [CNT_W-1:0] tmr_val;
    pull_pair_t       pulls;
    logic             pad_d, pad_oe_d, pu_d, pd_d, busy_d;

    assign pulls     = pull_resolve(PU_REQ, PD_REQ);
    assign state_dbg = state;

    io_dead_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (CLK),
        .rst      (RST),
        .load     (tmr_load),
        .load_val (RELOAD),
        .dec      (tmr_dec),
        .value    (tmr_val),
        .zero     (tmr_zero)
    );

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) state <= HIZ;
        else     state <= state_nx;
    end

    // Next-state and dead-timer control.
    always_comb begin
        state_nx = state;
        tmr_load = 1'b0;
        tmr_dec  = 1'b0;
        case (state)
            HIZ: begin
                if (OE_REQ) begin
                    state_nx = TURN_ON;
                    tmr_load = 1'b1;
                end
            end
            TURN_ON: begin
                if (!OE_REQ)       state_nx = HIZ;
                else if (tmr_zero) state_nx = DRIVE;
                else               tmr_dec  = 1'b1;
            end
            DRIVE: begin
                if (!OE_REQ) begin
                    state_nx = TURN_OFF;
                    tmr_load = 1'b1;
                end
            end
            TURN_OFF: begin
                if (tmr_zero) begin
                    if (OE_REQ) begin
                        state_nx = TURN_ON;
                        tmr_load = 1'b1;
                    end else begin
                        state_nx = HIZ;
                    end
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            default: state_nx = HIZ;
        endcase
    end

    // Output values for the coming state; pulls only exist in HIZ, drive only in DRIVE.
    always_comb begin
        pad_d    = 1'b0;
        pad_oe_d = 1'b0;
        pu_d     = 1'b0;
        pd_d     = 1'b0;
        busy_d   = (state_nx == TURN_ON) || (state_nx == TURN_OFF);
        case (state_nx)
            HIZ: begin
                pu_d = pulls.pu;
                pd_d = pulls.pd;
            end
            DRIVE: begin
                pad_oe_d = 1'b1;
                pad_d    = A;
            end
            default: ;
        endcase
    end

    // Output registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            PAD     <= 1'b0;
            PAD_OE  <= 1'b0;
            PU      <= 1'b0;
            PD      <= 1'b0;
            DRIVING <= 1'b0;
            BUSY    <= 1'b0;
        end else begin
            PAD     <= pad_d;
            PAD_OE  <= pad_oe_d;
            PU      <= pu_d;
            PD      <= pd_d;
            DRIVING <= pad_oe_d;
            BUSY    <= busy_d;
        end
    end

`ifdef IO_OUT_SEQ_CONTENTION_CHECK_EN
    logic drive_seen, mm_prev, mm_now;

    // Skip the first DRIVE cycle so the pad has settled before comparing.
    assign mm_now = (state == DRIVE) && drive_seen && (PAD_IN != PAD);

    // Two consecutive mismatches set the sticky flag; set beats clear.
    always_ff @(posedge CLK) begin
        if (RST) begin
            drive_seen <= 1'b0;
            mm_prev    <= 1'b0;
            CONTENTION <= 1'b0;
        end else begin
            drive_seen <= (state == DRIVE);
            mm_prev    <= mm_now;
            if (mm_now && mm_prev) CONTENTION <= 1'b1;
            else if (CLR_FLAG)     CONTENTION <= 1'b0;
        end
    end
`endif

    a_no_fight: assert property (@(posedge CLK) disable iff (RST) !(PAD_OE && (PU || PD)));
    a_timer_range: assert property (@(posedge CLK) disable iff (RST) tmr_val <= RELOAD);

endmodule

// File: tb/tb_io_out_seq.sv
// Directed plus randomized bench for io_out_seq against a behavioural model.
module tb_io_out_seq;

  localparam int DC = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic a = 1'b0;
  logic oe_req = 1'b0;
  logic pu_req = 1'b0;
  logic pd_req = 1'b0;
  logic pad, pad_oe, pu, pd, driving, busy;
  logic [1:0] state_dbg;
`ifdef IO_OUT_SEQ_CONTENTION_CHECK_EN
  logic pad_in = 1'b0;
  logic clr_flag = 1'b0;
  logic contention;
  logic flip = 1'b0;
`endif

  int n_assert = 0;
  int n_fail = 0;
  int cyc = 0;
  int last_pull = -1000;
  int last_oe = -1000;

  // model: phase 0 idle, 1 ramping up, 2 driving, 3 ramping down
  int m_phase = 0;
  int m_left = 0;
  logic m_pad = 1'b0, m_oe = 1'b0, m_pu = 1'b0, m_pd = 1'b0;
  int m_age = 0;
  int m_run = 0;
  logic m_cont = 1'b0;

  io_out_seq #(.DEAD_CYC(DC), .CNT_W(4)) dut (
    .CLK(clk),
    .RST(rst),
    .A(a),
    .OE_REQ(oe_req),
    .PU_REQ(pu_req),
    .PD_REQ(pd_req),
`ifdef IO_OUT_SEQ_CONTENTION_CHECK_EN
    .PAD_IN(pad_in),
    .CLR_FLAG(clr_flag),
    .CONTENTION(contention),
`endif
    .PAD(pad),
    .PAD_OE(pad_oe),
    .PU(pu),
    .PD(pd),
    .DRIVING(driving),
    .BUSY(busy),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic apply_pulls();
    m_pu = pu_req & ~pd_req;
    m_pd = pd_req & ~pu_req;
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_edge();
    int old_phase;
    old_phase = m_phase;
    if (rst) begin
      m_phase = 0; m_left = 0;
      m_pad = 1'b0; m_oe = 1'b0; m_pu = 1'b0; m_pd = 1'b0;
      m_age = 0; m_run = 0; m_cont = 1'b0;
      return;
    end
`ifdef IO_OUT_SEQ_CONTENTION_CHECK_EN
    if (m_phase == 2 && m_age >= 1 && pad_in !== m_pad) m_run++;
    else m_run = 0;
    if (m_run >= 2) m_cont = 1'b1;
    else if (clr_flag) m_cont = 1'b0;
`endif
    case (m_phase)
      0: begin
        if (oe_req) begin
          m_phase = 1; m_left = DC; m_pu = 1'b0; m_pd = 1'b0;
        end else apply_pulls();
      end
      1: begin
        if (!oe_req) begin
          m_phase = 0; apply_pulls();
        end else begin
          m_left--;
          if (m_left == 0) begin
            m_phase = 2; m_oe = 1'b1; m_pad = a;
          end
        end
      end
      2: begin
        if (!oe_req) begin
          m_phase = 3; m_left = DC; m_oe = 1'b0; m_pad = 1'b0;
        end else m_pad = a;
      end
      default: begin
        m_left--;
        if (m_left == 0) begin
          if (oe_req) begin
            m_phase = 1; m_left = DC;
          end else begin
            m_phase = 0; apply_pulls();
          end
        end
      end
    endcase
    m_age = (m_phase == 2) ? ((old_phase == 2) ? m_age + 1 : 0) : 0;
  endtask

  // One clock: model update at the edge, compare on the falling edge.
  task automatic step();
    logic ok;
    logic was_rst;
    was_rst = rst;
`ifdef IO_OUT_SEQ_CONTENTION_CHECK_EN
    pad_in = m_pad ^ flip;
`endif
    @(posedge clk);
    model_edge();
    @(negedge clk);
    cyc++;
    chk("outputs{pad,oe,pu,pd,drv,busy}", {2'b00, pad, pad_oe, pu, pd, driving, busy},
        {2'b00, m_pad, m_oe, m_pu, m_pd, m_oe, (m_phase == 1 || m_phase == 3)});
    chk("state", {6'd0, state_dbg}, 8'(m_phase));
    if (was_rst) begin
      last_pull = -1000;
      last_oe = -1000;
    end else begin
      if (pu || pd) last_pull = cyc;
      if (pad_oe) last_oe = cyc;
    end
    ok = !(pad_oe && (cyc - last_pull) <= DC) && !((pu || pd) && (cyc - last_oe) <= DC);
    chk("dead_time", {7'd0, ok}, 8'd1);
`ifdef IO_OUT_SEQ_CONTENTION_CHECK_EN
    chk("contention", {7'd0, contention}, {7'd0, m_cont});
`endif
  endtask

  initial begin
    // reset
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    // HIZ pulls, including the conflicting request
    pu_req = 1'b1; step(); step();
    pd_req = 1'b1; step(); step();
    pd_req = 1'b0; step();
    // turn-on, then toggle A while driving
    oe_req = 1'b1; step(); step(); step();
    for (int i = 0; i < 6; i++) begin
      a = ~a; step();
    end
    // turn-off back to pull-up
    oe_req = 1'b0; step(); step(); step(); step();
    // single-cycle request aborts the turn-on
    oe_req = 1'b1; step();
    oe_req = 1'b0; step(); step(); step();
    // re-request during turn-off
    oe_req = 1'b1; repeat (4) step();
    oe_req = 1'b0; step();
    oe_req = 1'b1; repeat (7) step();
    // reset while driving
    rst = 1'b1; step();
    rst = 1'b0; oe_req = 1'b0; step(); step();
`ifdef IO_OUT_SEQ_CONTENTION_CHECK_EN
    a = 1'b1; oe_req = 1'b1; repeat (5) step();
    flip = 1'b1; step();
    flip = 1'b0; step(); step();
    flip = 1'b1; step(); step();
    flip = 1'b0; step(); step(); step();
    clr_flag = 1'b1; step();
    clr_flag = 1'b0; step();
    oe_req = 1'b0; repeat (4) step();
`endif
    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 5) == 0) oe_req = ~oe_req;
      a = 1'($urandom);
      if ($urandom_range(0, 3) == 0) pu_req = 1'($urandom);
      if ($urandom_range(0, 3) == 0) pd_req = 1'($urandom);
`ifdef IO_OUT_SEQ_CONTENTION_CHECK_EN
      flip = ($urandom_range(0, 3) == 0);
      clr_flag = ($urandom_range(0, 19) == 0);
`endif
      step();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/io_out_seq.md
Name: io_out_seq

Overview:
- Output-direction companion to the input pad cell. Registers core data and output-enable requests and drives the pad driver's data, enable and PU/PD pull controls.
- Enforces break-before-make dead time between pull resistors and active drive, in both directions, so pulls and driver never fight on PAD.
- Sits between core logic and the bidirectional pad macro, one instance per pad.

Parameters:
- DEAD_CYC, 2, dead-time length in CLK cycles for each turnaround; legal range 1..15, 0 is illegal (elaboration error).
- CNT_W, 4, dead-time counter width; must hold DEAD_CYC.

Ports:
- CLK  input  1  block clock.
- RST  input  1  reset, synchronous, active-high.
- A  input  1  core data to drive on the pad.
- OE_REQ  input  1  core request to drive the pad (1) or release it (0).
- PU_REQ  input  1  core pull-up request, honoured only while released.
- PD_REQ  input  1  core pull-down request, honoured only while released.
- PAD  output  1  data to the pad driver.
- PAD_OE  output  1  driver enable to the pad macro.
- PU  output  1  pull-up control to the pad macro.
- PD  output  1  pull-down control to the pad macro.
- DRIVING  output  1  high exactly when PAD_OE is high.
- BUSY  output  1  high in either turnaround state.

Behaviour:
- All outputs are registered. Reset values: PAD=0, PAD_OE=0, PU=0, PD=0, DRIVING=0, BUSY=0, state=HIZ, counter=0.
- Reset asserted in any state returns the block to HIZ on the next edge, with all outputs at their reset values.
- States: HIZ, TURN_ON, DRIVE, TURN_OFF.
- HIZ:
  - PAD_OE=0 and PAD=0.
  - PU = PU_REQ & ~PD_REQ; PD = PD_REQ & ~PU_REQ. If both are requested, both outputs are 0.
  - Pull outputs follow the requests with 1-cycle latency.
  - When OE_REQ=1 is sampled: go to TURN_ON, load counter=DEAD_CYC-1, set PU=PD=0.
- TURN_ON:
  - PU=PD=0, PAD_OE=0, BUSY=1.
  - Counter decrements each cycle. At counter=0: go to DRIVE, set PAD_OE=1, PAD=A.
  - If OE_REQ=0 is sampled: abort to HIZ next cycle and restore pulls from the current requests.
  - TURN_ON therefore lasts exactly DEAD_CYC cycles.
- DRIVE:
  - PAD_OE=1; PAD = A registered (1-cycle latency); PU=PD=0 regardless of requests.
  - When OE_REQ=0 is sampled: go to TURN_OFF, load counter=DEAD_CYC-1, set PAD_OE=0, PAD=0 on the same edge.
- TURN_OFF:
  - PAD_OE=0, PU=PD=0, BUSY=1; lasts DEAD_CYC cycles and cannot be aborted.
  - At counter=0, if OE_REQ=1: go directly to TURN_ON with pulls kept at 0 and counter reloaded.
  - At counter=0, if OE_REQ=0: go to HIZ and apply pulls from the requests.
- Invariants, checked by assertions:
  - PAD_OE & (PU|PD) is never 1.
  - PAD_OE is never high within DEAD_CYC cycles of PU or PD being high, in either order.
- Changes on A outside DRIVE have no effect on PAD.

Optional Feature:
- Macro IO_OUT_SEQ_CONTENTION_CHECK_EN.
- When defined, the block adds:
  - input PAD_IN: pad readback, driven by the input cell Y.
  - input CLR_FLAG: clears the contention flag.
  - output CONTENTION: sticky contention flag, reset 0.
- Checking rules:
  - Checking starts 1 cycle after entry to DRIVE.
  - If PAD_IN != PAD on 2 consecutive cycles, CONTENTION is set to 1 on the next edge.
  - A single-cycle mismatch is ignored.
  - CLR_FLAG=1 clears CONTENTION; if a set condition coincides with CLR_FLAG, set wins.
- When not defined, the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- Shared package io_pad_pkg holds:
  - enum io_out_state_t {HIZ, TURN_ON, DRIVE, TURN_OFF}.
  - Constant IO_DEAD_CYC_MAX=15.
  - Function pull_resolve(pu_req, pd_req), returning the conflict-free pull pair.
- One sub-module, io_dead_timer: a loadable down-counter with load, value and zero flag, parameterised by CNT_W. It is instantiated once and shared by TURN_ON and TURN_OFF.

Test Plan:
- Reset/HIZ pulls: RST then PU_REQ=1, PD_REQ=0 → PU=1 one cycle later. Then PU_REQ=PD_REQ=1 → PU=PD=0 one cycle later. PAD_OE=0 throughout.
- Turn-on timing (DEAD_CYC=2, PU_REQ=1): OE_REQ=1 sampled at edge 0 → PU=0 after edge 0, BUSY=1 after edges 0–1, PAD_OE=1 and DRIVING=1 after edge 2. A toggling 0/1 appears on PAD 1 cycle later.
- Turn-off timing: from DRIVE, OE_REQ=0 at edge n → PAD_OE=0, PAD=0 after edge n; PU=0 after edges n and n+1; PU=1 after edge n+2.
- Abort and re-request:
  - OE_REQ pulses high for 1 cycle with DEAD_CYC=3 → returns to HIZ with PAD_OE never 1.
  - OE_REQ re-asserted mid TURN_OFF → TURN_OFF completes, then TURN_ON with PU held 0.
- Reset mid-DRIVE: RST=1 while PAD_OE=1 → all outputs 0 after the next edge, state HIZ.
- Contention (with macro): in DRIVE with PAD=1, force PAD_IN=0 for 1 cycle → CONTENTION=0. Force it for 2 cycles → CONTENTION=1, and it stays 1 until CLR_FLAG is asserted.
